// File: rtl/sp3_downlink_frame_tx_if.sv
// Upstream word stream into the downlink frame transmitter: {ic,ec,data} with valid/ready.
interface sp3_downlink_frame_tx_if;
    logic [31:0] s_data_i;
    logic [1:0]  s_ec_i;
    logic [1:0]  s_ic_i;
    logic        s_valid_i;
    logic        s_ready_o;

    modport master (
        output s_data_i,
        output s_ec_i,
        output s_ic_i,
        output s_valid_i,
        input  s_ready_o
    );

    modport slave (
        input  s_data_i,
        input  s_ec_i,
        input  s_ic_i,
        input  s_valid_i,
        output s_ready_o
    );
endinterface

// File: rtl/sp3_downlink_frame_tx.sv
// Downlink frame transmitter: FIFO of 36-bit words, one frame (data or idle) per FRAME_DIV-clock slot.
// Optional data scrambling is enabled by defining SP3_DL_SCRAMBLER_EN.
module sp3_downlink_frame_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FRAME_DIV  = 4,
    parameter logic [31:0] IDLE_WORD  = 32'hACAC_ACAC
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          enable_i,
    input  logic                          flush_i,
    sp3_downlink_frame_tx_if.slave        s_if,
    output logic [35:0]                   frame_o,
    output logic                          frame_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [15:0]                   underflow_cnt_o,
    output logic [31:0]                   frames_sent_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(FRAME_DIV);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT   = CW'(FRAME_DIV - 1);

    logic [35:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [35:0]   frame_q, frame_d;
    logic          frame_valid_q;
    logic [15:0]   underflow_q, underflow_d;
    logic [31:0]   frames_q, frames_d;
    logic          slot, push, pop;
    logic [35:0]   head;
    logic [31:0]   raw_data, out_data;

    assign slot = enable_i && (cnt_q == LAST_CNT);
    // flush wins over both ends of the FIFO; ready is from the registered level only
    assign push = s_if.s_valid_i && ready_q && !flush_i;
    assign pop  = slot && (level_q != '0) && !flush_i;
    assign head = mem[rptr_q];
    assign raw_data = pop ? head[31:0] : IDLE_WORD;

`ifdef SP3_DL_SCRAMBLER_EN
    logic [31:0] lfsr_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            lfsr_q <= 32'hFFFF_FFFF;
        end else if (slot) begin
            lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end
    end

    assign out_data = raw_data ^ lfsr_q;
`else
    assign out_data = raw_data;
`endif

    always_comb begin
        cnt_d = '0;
        if (enable_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push && !pop) level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        frame_d     = frame_q;
        underflow_d = underflow_q;
        frames_d    = frames_q;
        if (slot) begin
            frame_d  = {(pop ? head[35:32] : 4'hF), out_data};
            frames_d = frames_q + 32'd1;
            if (!pop && (underflow_q != 16'hFFFF)) begin
                underflow_d = underflow_q + 16'd1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem[wptr_q] <= {s_if.s_ic_i, s_if.s_ec_i, s_if.s_data_i};
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            level_q       <= '0;
            ready_q       <= 1'b0;
            cnt_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            underflow_q   <= '0;
            frames_q      <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            level_q       <= level_d;
            ready_q       <= (level_d != FULL_LEVEL);
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            frame_valid_q <= slot;
            underflow_q   <= underflow_d;
            frames_q      <= frames_d;
        end
    end

    assign s_if.s_ready_o    = ready_q;
    assign frame_o           = frame_q;
    assign frame_valid_o     = frame_valid_q;
    assign fifo_level_o      = level_q;
    assign underflow_cnt_o   = underflow_q;
    assign frames_sent_cnt_o = frames_q;

endmodule
